kbd_cell_ctrl: RTL and testbench

Command sequencer between the keyboard key-code decoder and the 3×3 colour-cell register that feeds the VGA pixel generator. It turns a stream of 4-bit key codes into single-cell colour writes ("digit, then colour") and a "clear all" sequence. Every register write is deferred to vertical blanking so a frame is never drawn with a half-updated grid. Selection timeouts, aborts and dropped keys are reported back to the keyboard/status logic.

---
 rtl/kbd_pkg.sv | 36 +++
 rtl/kbd_cell_ctrl_if.sv | 27 ++
 rtl/kbd_timer.sv | 32 +++
 rtl/kbd_cell_ctrl.sv | 127 ++++++++++++
 tb/tb_kbd_cell_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/kbd_pkg.sv
// Shared key codes, colour constants and state encoding
// for the keyboard-to-cell-register command sequencer.
package kbd_pkg;

  localparam logic [3:0] KEY_CLR   = 4'd0;
  localparam logic [3:0] KEY_COL_A = 4'd10;
  localparam logic [3:0] KEY_COL_B = 4'd11;
  localparam logic [3:0] KEY_COL_C = 4'd12;

  // {r[2:0], g[2:0], b[2:0]}
  localparam logic [8:0] RGB_A = 9'b111_011_111;
  localparam logic [8:0] RGB_B = 9'b000_111_000;
  localparam logic [8:0] RGB_C = 9'b001_111_111;

  typedef enum logic [1:0] {
    IDLE,
    SEL,
    PEND,
    CLR
  } state_t;

  function automatic logic [8:0] col_rgb(
    input logic [3:0] code
  );
    logic [8:0] rgb;
    rgb = '0;
    case (code)
      KEY_COL_A: rgb = RGB_A;
      KEY_COL_B: rgb = RGB_B;
      KEY_COL_C: rgb = RGB_C;
      default:   rgb = '0;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/kbd_cell_ctrl_if.sv
// Key/vblank inputs and cell-register write bus of kbd_cell_ctrl.
// master: keyboard/VGA side; slave: the sequencer.
interface kbd_cell_ctrl_if;

  logic       key_valid;
  logic [3:0] key_code;
  logic       vblank;
  logic       wr_en;
  logic [3:0] wr_idx;
  logic [8:0] wr_rgb;
  logic [3:0] sel_cell;
  logic       busy;
  logic       err;

  modport master (
    output key_valid, key_code, vblank,
    input  wr_en, wr_idx, wr_rgb,
    input  sel_cell, busy, err
  );

  modport slave (
    input  key_valid, key_code, vblank,
    output wr_en, wr_idx, wr_rgb,
    output sel_cell, busy, err
  );

endinterface

// File: rtl/kbd_timer.sv
// Selection timer: clr/en counter, done at TIMEOUT_CYCLES-1.
// Ports: clk, rst, clr, en in; done out. Saturates at done.
module kbd_timer #(
  parameter int TIMEOUT_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  assign done = (count == LAST);

  // expiry is checked before increment, so never wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !done) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/kbd_cell_ctrl.sv
// Key-code sequencer: digit+colour writes and clear-all,
// writes deferred to vblank. Ports: clk, rst, bus (slave).
module kbd_cell_ctrl
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 25_000_000,
  parameter int NCELLS         = 9
) (
  input logic            clk,
  input logic            rst,
  kbd_cell_ctrl_if.slave bus
);

  state_t     state;
  logic [8:0] rgb_q;
  logic [3:0] clr_idx;
  logic       tmr_done;
  logic       tmr_clr;
  logic       tmr_en;
  logic       is_dig;
  logic       is_clr;
  logic       is_col;

  assign is_clr = (bus.key_code == KEY_CLR);
  assign is_dig = (bus.key_code >= 4'd1) &&
                  (bus.key_code <= 4'(NCELLS));
  assign is_col = (bus.key_code >= KEY_COL_A) &&
                  (bus.key_code <= KEY_COL_C);

  assign tmr_en  = (state == SEL);
  assign tmr_clr = bus.key_valid && is_dig &&
                   ((state == IDLE) || (state == SEL));

  kbd_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr),
    .en  (tmr_en),
    .done(tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rgb_q        <= '0;
      clr_idx      <= 4'd1;
      bus.wr_en    <= 1'b0;
      bus.wr_idx   <= '0;
      bus.wr_rgb   <= '0;
      bus.sel_cell <= '0;
      bus.busy     <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      bus.err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.key_valid) begin
            unique case (1'b1)
              is_dig: begin
                bus.sel_cell <= bus.key_code;
                state        <= SEL;
              end
              is_clr: begin
                clr_idx  <= 4'd1;
                bus.busy <= 1'b1;
                state    <= CLR;
              end
              is_col:  bus.err <= 1'b1;
              default: ;
            endcase
          end
        end
        SEL: begin
          // any key beats a same-cycle expiry
          if (bus.key_valid) begin
            unique case (1'b1)
              is_dig: bus.sel_cell <= bus.key_code;
              is_col: begin
                rgb_q    <= col_rgb(bus.key_code);
                bus.busy <= 1'b1;
                state    <= PEND;
              end
              is_clr: begin
                bus.sel_cell <= '0;
                state        <= IDLE;
              end
              default: ;
            endcase
          end else if (tmr_done) begin
            bus.sel_cell <= '0;
            bus.err      <= 1'b1;
            state        <= IDLE;
          end
        end
        PEND: begin
          bus.err <= bus.key_valid;
          if (bus.vblank) begin
            bus.wr_en    <= 1'b1;
            bus.wr_idx   <= bus.sel_cell;
            bus.wr_rgb   <= rgb_q;
            bus.sel_cell <= '0;
            bus.busy     <= 1'b0;
            state        <= IDLE;
          end
        end
        CLR: begin
          bus.err <= bus.key_valid;
          if (bus.vblank) begin
            bus.wr_en  <= 1'b1;
            bus.wr_idx <= clr_idx;
            bus.wr_rgb <= '0;
            clr_idx    <= clr_idx + 4'd1;
            if (clr_idx == 4'(NCELLS)) begin
              bus.busy <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_cell_ctrl.sv
// Scoreboard bench for kbd_cell_ctrl: directed key sequences,
// expected writes/err pulses queued with their edge numbers.
module tb_kbd_cell_ctrl;
  import kbd_pkg::*;

  typedef struct {
    logic [3:0] idx;
    logic [8:0] rgb;
    int         cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  wr_t  exp_wr[$];
  int   exp_err[$];

  kbd_cell_ctrl_if bus ();

  kbd_cell_ctrl #(
    .TIMEOUT_CYCLES(16),
    .NCELLS        (9)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] k, output int n);
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    n = cyc;
  endtask

  task automatic push_wr(int idx, int rgb, int c);
    wr_t e;
    e.idx = 4'(idx);
    e.rgb = 9'(rgb);
    e.cyc = c;
    exp_wr.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    int  c;
    if (bus.wr_en === 1'b1) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL wr_unexp: idx=%0d rgb=%b cyc=%0d",
                 bus.wr_idx, bus.wr_rgb, cyc);
      end else begin
        e = exp_wr.pop_front();
        if (bus.wr_idx !== e.idx || bus.wr_rgb !== e.rgb ||
            cyc != e.cyc) begin
          errors++;
          $display("FAIL wr: got idx=%0d rgb=%b cyc=%0d %s%0d rgb=%b cyc=%0d",
                   bus.wr_idx, bus.wr_rgb, cyc,
                   "expected idx=", e.idx, e.rgb, e.cyc);
        end
      end
    end
    if (bus.err === 1'b1) begin
      checks++;
      if (exp_err.size() == 0) begin
        errors++;
        $display("FAIL err_unexp: cyc=%0d", cyc);
      end else begin
        c = exp_err.pop_front();
        if (cyc != c) begin
          errors++;
          $display("FAIL err_cyc: got %0d expected %0d",
                   cyc, c);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    int base;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    bus.vblank    = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_wr_en", int'(bus.wr_en), 0);
    chk("rst_wr_idx", int'(bus.wr_idx), 0);
    chk("rst_wr_rgb", int'(bus.wr_rgb), 0);
    chk("rst_sel", int'(bus.sel_cell), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_err", int'(bus.err), 0);

    // digit 3, colour 11, write waits for vblank
    send(4'd3, n);
    chk("t1_sel3", int'(bus.sel_cell), 3);
    send(4'd11, n);
    chk("t1_busy", int'(bus.busy), 1);
    tick(5);
    chk("t1_busy_hold", int'(bus.busy), 1);
    chk("t1_sel_hold", int'(bus.sel_cell), 3);
    bus.vblank = 1'b1;
    push_wr(3, 9'b000_111_000, cyc + 1);
    tick(1);
    bus.vblank = 1'b0;
    chk("t1_sel0", int'(bus.sel_cell), 0);
    chk("t1_busy0", int'(bus.busy), 0);

    // timeout 16 cycles after the digit
    send(4'd5, n);
    exp_err.push_back(n + 16);
    tick(20);
    chk("t2_sel0", int'(bus.sel_cell), 0);
    chk("t2_busy0", int'(bus.busy), 0);

    // colour with no selection, then 7,2,10
    send(4'd12, n);
    exp_err.push_back(n);
    chk("t3_sel0", int'(bus.sel_cell), 0);
    send(4'd7, n);
    send(4'd2, n);
    chk("t3_sel2", int'(bus.sel_cell), 2);
    send(4'd10, n);
    bus.vblank = 1'b1;
    push_wr(2, 9'b111_011_111, cyc + 1);
    tick(1);
    bus.vblank = 1'b0;

    // clear: 4 writes, pause 10, 5 writes
    send(4'd0, n);
    chk("t4_busy", int'(bus.busy), 1);
    base = cyc;
    for (int i = 1; i <= 4; i++)
      push_wr(i, 0, base + i);
    bus.vblank = 1'b1;
    tick(4);
    bus.vblank = 1'b0;
    tick(10);
    chk("t4_busy_pause", int'(bus.busy), 1);
    base = cyc;
    for (int i = 5; i <= 9; i++)
      push_wr(i, 0, base + i - 4);
    bus.vblank = 1'b1;
    tick(5);
    bus.vblank = 1'b0;
    chk("t4_busy0", int'(bus.busy), 0);
    tick(2);

    // key dropped in the same cycle as a PEND write
    send(4'd6, n);
    send(4'd10, n);
    bus.vblank = 1'b1;
    push_wr(6, 9'b111_011_111, cyc + 1);
    exp_err.push_back(cyc + 1);
    send(4'd9, n);
    bus.vblank = 1'b0;
    chk("t5_sel0", int'(bus.sel_cell), 0);
    chk("t5_busy0", int'(bus.busy), 0);

    // digit on the expiry edge wins, no err
    send(4'd5, n);
    tick(15);
    send(4'd8, n);
    chk("t5_sel8", int'(bus.sel_cell), 8);
    send(4'd0, n);
    chk("t5_abort", int'(bus.sel_cell), 0);
    tick(2);

    // reset after the third clear write
    bus.vblank = 1'b1;
    send(4'd0, n);
    for (int i = 1; i <= 3; i++)
      push_wr(i, 0, n + i);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t6_wr_en", int'(bus.wr_en), 0);
    chk("t6_wr_idx", int'(bus.wr_idx), 0);
    chk("t6_wr_rgb", int'(bus.wr_rgb), 0);
    chk("t6_sel", int'(bus.sel_cell), 0);
    chk("t6_busy", int'(bus.busy), 0);
    chk("t6_err", int'(bus.err), 0);
    tick(3);
    bus.vblank = 1'b0;
    send(4'd4, n);
    chk("t6_sel4", int'(bus.sel_cell), 4);
    send(4'd0, n);
    chk("t6_abort", int'(bus.sel_cell), 0);

    tick(20);
    chk("wr_q_empty", exp_wr.size(), 0);
    chk("err_q_empty", exp_err.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
